// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control-loop tick scheduler.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IMU  = 2'd1,
        ST_PID  = 2'd2,
        ST_PWM  = 2'd3
    } sched_state_e;

    localparam int unsigned TICK_PERIOD_CYC = 32'd6000;
    localparam int unsigned TIMEOUT_CYC_DEF = 32'd4000;
    localparam int unsigned CNT_W_DEF       = 32'd8;

    // Stage that follows a completed stage; PWM completion closes the loop.
    function automatic sched_state_e stage_next(input sched_state_e s);
        sched_state_e n;
        case (s)
            ST_IMU:  n = ST_PID;
            ST_PID:  n = ST_PWM;
            ST_PWM:  n = ST_IDLE;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ctrl_tick_sched_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_12mhz,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count events, holding at all-ones.
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/ctrl_tick_sched.sv
// Control-loop scheduler: IMU -> PID -> PWM per tick, with overrun accounting.
// Optional per-stage watchdog enabled by defining CTRL_TICK_SCHED_WDOG_EN.
module ctrl_tick_sched
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk_12mhz,
    input  logic             reset_n,
    input  logic             tick_en,
    input  logic             run_en,
    input  logic             stat_clr,
    output logic             imu_req,
    input  logic             imu_done,
    output logic             pid_req,
    input  logic             pid_done,
    output logic             pwm_req,
    input  logic             pwm_done,
    output logic             busy,
    output logic             cycle_done,
    output logic [1:0]       stage,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             overrun_flag,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic             timeout_flag
);

    if (TIMEOUT_CYC < 32'd2) begin : g_timeout_chk
        $error("ctrl_tick_sched: TIMEOUT_CYC must be at least 2");
    end

    sched_state_e state_r;
    sched_state_e next_state_s;
    logic         imu_req_r;
    logic         pid_req_r;
    logic         pwm_req_r;
    logic         busy_r;
    logic         cycle_done_r;
    logic         overrun_flag_r;
    logic         done_cur_s;
    logic         overrun_s;
    logic         timeout_s;

    // Only the done belonging to the active stage is honoured.
    always_comb begin
        done_cur_s = 1'b0;
        case (state_r)
            ST_IMU:  done_cur_s = imu_done;
            ST_PID:  done_cur_s = pid_done;
            ST_PWM:  done_cur_s = pwm_done;
            default: done_cur_s = 1'b0;
        endcase
    end

    // A tick arriving while an iteration is in flight is dropped and counted.
    always_comb begin
        if (state_r != ST_IDLE) begin
            overrun_s = tick_en;
        end else begin
            overrun_s = 1'b0;
        end
    end

`ifdef CTRL_TICK_SCHED_WDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

    logic [WD_W-1:0] wdog_cnt_r;
    logic            timeout_flag_r;

    // Stage-age counter: zero on every state entry, counts while in a stage.
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r == ST_IDLE) || done_cur_s || timeout_s) begin
            wdog_cnt_r <= {WD_W{1'b0}};
        end else begin
            wdog_cnt_r <= wdog_cnt_r + WD_W'(1);
        end
    end

    // A done in the final watchdog cycle still advances the stage.
    always_comb begin
        if ((state_r != ST_IDLE) && (wdog_cnt_r == WD_W'(TIMEOUT_CYC - 32'd1))) begin
            timeout_s = ~done_cur_s;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Sticky abort indication; clear wins over a coincident abort.
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            timeout_flag_r <= 1'b0;
        end else if (stat_clr) begin
            timeout_flag_r <= 1'b0;
        end else if (timeout_s) begin
            timeout_flag_r <= 1'b1;
        end else begin
            timeout_flag_r <= timeout_flag_r;
        end
    end

    sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .clk_12mhz (clk_12mhz),
        .reset_n   (reset_n),
        .clr       (stat_clr),
        .inc       (timeout_s),
        .cnt       (timeout_cnt)
    );

    assign timeout_flag = timeout_flag_r;
`else
    // Without the watchdog, stages wait indefinitely for their done.
    always_comb begin
        timeout_s = 1'b0;
    end

    assign timeout_cnt  = {CNT_W{1'b0}};
    assign timeout_flag = 1'b0;
`endif

    // Next-state selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_en && run_en) begin
                    next_state_s = ST_IMU;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_IMU, ST_PID, ST_PWM: begin
                if (done_cur_s) begin
                    next_state_s = stage_next(state_r);
                end else if (timeout_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Scheduler state and its registered handshake/status outputs.
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            imu_req_r    <= 1'b0;
            pid_req_r    <= 1'b0;
            pwm_req_r    <= 1'b0;
            busy_r       <= 1'b0;
            cycle_done_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            imu_req_r    <= (next_state_s == ST_IMU);
            pid_req_r    <= (next_state_s == ST_PID);
            pwm_req_r    <= (next_state_s == ST_PWM);
            busy_r       <= (next_state_s != ST_IDLE);
            cycle_done_r <= (state_r == ST_PWM) && pwm_done;
        end
    end

    // Sticky overrun indication; clear wins over a coincident overrun.
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            overrun_flag_r <= 1'b0;
        end else if (stat_clr) begin
            overrun_flag_r <= 1'b0;
        end else if (overrun_s) begin
            overrun_flag_r <= 1'b1;
        end else begin
            overrun_flag_r <= overrun_flag_r;
        end
    end

    sat_counter #(.W(CNT_W)) u_overrun_cnt (
        .clk_12mhz (clk_12mhz),
        .reset_n   (reset_n),
        .clr       (stat_clr),
        .inc       (overrun_s),
        .cnt       (overrun_cnt)
    );

    assign imu_req      = imu_req_r;
    assign pid_req      = pid_req_r;
    assign pwm_req      = pwm_req_r;
    assign busy         = busy_r;
    assign cycle_done   = cycle_done_r;
    assign stage        = state_r;
    assign overrun_flag = overrun_flag_r;

endmodule

// File: tb/tb_ctrl_tick_sched.sv
// Self-checking bench for ctrl_tick_sched: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the scheduling rules.
`timescale 1ns/1ps
module tb_ctrl_tick_sched;

    localparam int TIMEOUT = 4000;
    localparam int CW      = 8;
    localparam int SAT     = 255;
`ifdef CTRL_TICK_SCHED_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic          clk_12mhz = 1'b0;
    logic          reset_n   = 1'b0;
    logic          tick_en   = 1'b0;
    logic          run_en    = 1'b1;
    logic          stat_clr  = 1'b0;
    logic          imu_done  = 1'b0;
    logic          pid_done  = 1'b0;
    logic          pwm_done  = 1'b0;
    logic          imu_req, pid_req, pwm_req, busy, cycle_done;
    logic [1:0]    stage;
    logic [CW-1:0] overrun_cnt, timeout_cnt;
    logic          overrun_flag, timeout_flag;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0=idle,1=imu,2=pid,3=pwm; age = cycles spent in current stage.
    int m_phase = 0, m_age = 0, m_ovr = 0, m_tmo = 0;
    bit m_oflag = 1'b0, m_tflag = 1'b0, m_cdone = 1'b0;

    ctrl_tick_sched #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(CW)) dut (
        .clk_12mhz    (clk_12mhz),
        .reset_n      (reset_n),
        .tick_en      (tick_en),
        .run_en       (run_en),
        .stat_clr     (stat_clr),
        .imu_req      (imu_req),
        .imu_done     (imu_done),
        .pid_req      (pid_req),
        .pid_done     (pid_done),
        .pwm_req      (pwm_req),
        .pwm_done     (pwm_done),
        .busy         (busy),
        .cycle_done   (cycle_done),
        .stage        (stage),
        .overrun_cnt  (overrun_cnt),
        .overrun_flag (overrun_flag),
        .timeout_cnt  (timeout_cnt),
        .timeout_flag (timeout_flag)
    );

    always #42 clk_12mhz = ~clk_12mhz;

    task automatic model_clear();
        m_phase = 0; m_age = 0; m_ovr = 0; m_tmo = 0;
        m_oflag = 1'b0; m_tflag = 1'b0; m_cdone = 1'b0;
    endtask

    task automatic model_step();
        bit d, ev_ovr, ev_to;
        m_cdone = 1'b0;
        ev_to   = 1'b0;
        if (!reset_n) begin
            model_clear();
            return;
        end
        ev_ovr = tick_en && (m_phase != 0);
        if (m_phase == 0) begin
            m_age = 0;
            if (tick_en && run_en) m_phase = 1;
        end else begin
            d = (m_phase == 1) ? imu_done : (m_phase == 2) ? pid_done : pwm_done;
            m_age++;
            if (d) begin
                m_cdone = (m_phase == 3);
                m_phase = (m_phase + 1) % 4;
                m_age   = 0;
            end else if (WDOG_ON && m_age >= TIMEOUT) begin
                m_phase = 0;
                m_age   = 0;
                ev_to   = 1'b1;
            end
        end
        if (ev_ovr) begin
            m_ovr   = (m_ovr < SAT) ? m_ovr + 1 : SAT;
            m_oflag = 1'b1;
        end
        if (ev_to) begin
            m_tmo   = (m_tmo < SAT) ? m_tmo + 1 : SAT;
            m_tflag = 1'b1;
        end
        if (stat_clr) begin
            m_ovr = 0; m_oflag = 1'b0; m_tmo = 0; m_tflag = 1'b0;
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, then outputs settle.
    task automatic cycle();
        @(posedge clk_12mhz);
        model_step();
        #1;
    endtask

    // Walk an iteration that is already in IMU to completion, done one cycle after each req.
    task automatic finish_iter();
        for (int s = 0; s < 3; s++) begin
            imu_done = imu_req; pid_done = pid_req; pwm_done = pwm_req;
            cycle();
            imu_done = 1'b0; pid_done = 1'b0; pwm_done = 1'b0;
        end
    endtask

    task automatic pulse_tick();
        tick_en = 1'b1;
        cycle();
        tick_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cycle();
        n_checks++;
        if ({imu_req, pid_req, pwm_req, busy, cycle_done} !== 5'b0) begin
            n_errors++; $display("FAIL reset_outputs: got %b required 00000", {imu_req, pid_req, pwm_req, busy, cycle_done});
        end
        n_checks++;
        if ({stage, overrun_cnt, overrun_flag, timeout_cnt, timeout_flag} !== 20'd0) begin
            n_errors++; $display("FAIL reset_status: stage=%0d ovr=%0d of=%0d tmo=%0d tf=%0d required all 0",
                                 stage, overrun_cnt, overrun_flag, timeout_cnt, timeout_flag);
        end
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        int lat;
        pulse_tick();
        n_checks++;
        if (!(imu_req === 1'b1 && busy === 1'b1 && stage === 2'd1 && pid_req === 1'b0)) begin
            n_errors++; $display("FAIL basic_imu: imu=%b busy=%b stage=%0d required 1 1 1", imu_req, busy, stage);
        end
        imu_done = 1'b1; cycle(); imu_done = 1'b0;
        n_checks++;
        if (!(imu_req === 1'b0 && pid_req === 1'b1 && stage === 2'd2)) begin
            n_errors++; $display("FAIL basic_pid: imu=%b pid=%b stage=%0d required 0 1 2", imu_req, pid_req, stage);
        end
        pid_done = 1'b1; cycle(); pid_done = 1'b0;
        n_checks++;
        if (!(pid_req === 1'b0 && pwm_req === 1'b1 && stage === 2'd3)) begin
            n_errors++; $display("FAIL basic_pwm: pid=%b pwm=%b stage=%0d required 0 1 3", pid_req, pwm_req, stage);
        end
        pwm_done = 1'b1; cycle(); pwm_done = 1'b0;
        n_checks++;
        if (!(pwm_req === 1'b0 && cycle_done === 1'b1 && busy === 1'b0 && stage === 2'd0)) begin
            n_errors++; $display("FAIL basic_done: pwm=%b cdone=%b busy=%b required 0 1 0", pwm_req, cycle_done, busy);
        end
        cycle();
        n_checks++;
        if (cycle_done !== 1'b0) begin
            n_errors++; $display("FAIL basic_cdone_pulse: cycle_done=%b required 0", cycle_done);
        end
        // Latency from tick to cycle_done with immediate dones.
        lat = 0;
        pulse_tick(); lat++;
        while (cycle_done !== 1'b1 && lat < 20) begin
            imu_done = imu_req; pid_done = pid_req; pwm_done = pwm_req;
            cycle(); lat++;
            imu_done = 1'b0; pid_done = 1'b0; pwm_done = 1'b0;
        end
        n_checks++;
        if (lat !== 4) begin
            n_errors++; $display("FAIL basic_latency: got %0d cycles required 4", lat);
        end
        n_checks++;
        if (overrun_cnt !== 8'd0 || overrun_flag !== 1'b0) begin
            n_errors++; $display("FAIL basic_no_overrun: cnt=%0d flag=%b required 0 0", overrun_cnt, overrun_flag);
        end
    endtask

    task automatic test_overrun();
        bit seen;
        pulse_tick();
        imu_done = 1'b1; cycle(); imu_done = 1'b0;
        pulse_tick();
        n_checks++;
        if (overrun_cnt !== 8'd1 || overrun_flag !== 1'b1 || pid_req !== 1'b1) begin
            n_errors++; $display("FAIL overrun_first: cnt=%0d flag=%b pid_req=%b required 1 1 1", overrun_cnt, overrun_flag, pid_req);
        end
        seen = 1'b0;
        for (int s = 0; s < 2; s++) begin
            pid_done = pid_req; pwm_done = pwm_req;
            cycle();
            pid_done = 1'b0; pwm_done = 1'b0;
            seen |= cycle_done;
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_errors++; $display("FAIL overrun_completes: cycle_done seen=%b required 1", seen);
        end
        // Saturation: hold in IMU and hammer ticks.
        pulse_tick();
        tick_en = 1'b1;
        repeat (300) cycle();
        tick_en = 1'b0;
        n_checks++;
        if (overrun_cnt !== 8'd255 || overrun_cnt !== CW'(m_ovr)) begin
            n_errors++; $display("FAIL overrun_saturate: got %0d required 255 (model %0d)", overrun_cnt, m_ovr);
        end
        finish_iter();
    endtask

    task automatic test_run_en();
        bit seen;
        run_en = 1'b0;
        pulse_tick();
        n_checks++;
        if (busy !== 1'b0 || imu_req !== 1'b0) begin
            n_errors++; $display("FAIL run_en_low_ignored: busy=%b imu_req=%b required 0 0", busy, imu_req);
        end
        run_en = 1'b1;
        pulse_tick();
        run_en = 1'b0;
        cycle();
        seen = 1'b0;
        for (int s = 0; s < 3; s++) begin
            imu_done = imu_req; pid_done = pid_req; pwm_done = pwm_req;
            cycle();
            imu_done = 1'b0; pid_done = 1'b0; pwm_done = 1'b0;
            seen |= cycle_done;
        end
        n_checks++;
        if (seen !== 1'b1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL run_en_drop_completes: cdone seen=%b busy=%b required 1 0", seen, busy);
        end
        run_en = 1'b1;
    endtask

    task automatic test_tick_pwm_done_and_clr();
        stat_clr = 1'b1; cycle(); stat_clr = 1'b0;
        n_checks++;
        if (overrun_cnt !== 8'd0 || overrun_flag !== 1'b0) begin
            n_errors++; $display("FAIL stat_clr: cnt=%0d flag=%b required 0 0", overrun_cnt, overrun_flag);
        end
        pulse_tick();
        imu_done = 1'b1; cycle(); imu_done = 1'b0;
        pid_done = 1'b1; cycle(); pid_done = 1'b0;
        pwm_done = 1'b1; tick_en = 1'b1; cycle(); pwm_done = 1'b0; tick_en = 1'b0;
        n_checks++;
        if (overrun_cnt !== 8'd1 || stage !== 2'd0 || busy !== 1'b0 || cycle_done !== 1'b1) begin
            n_errors++; $display("FAIL tick_with_pwm_done: cnt=%0d stage=%0d busy=%b cdone=%b required 1 0 0 1",
                                 overrun_cnt, stage, busy, cycle_done);
        end
        pulse_tick();
        tick_en = 1'b1; stat_clr = 1'b1; cycle(); tick_en = 1'b0; stat_clr = 1'b0;
        n_checks++;
        if (overrun_cnt !== 8'd0 || overrun_flag !== 1'b0) begin
            n_errors++; $display("FAIL clr_beats_overrun: cnt=%0d flag=%b required 0 0", overrun_cnt, overrun_flag);
        end
        finish_iter();
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        pulse_tick();
        imu_done = 1'b1; cycle(); imu_done = 1'b0;
        n = 0; seen = 1'b0;
        while (pid_req === 1'b1 && n < TIMEOUT + 1000) begin
            n++; cycle();
            seen |= cycle_done;
        end
        if (WDOG_ON) begin
            n_checks++;
            if (n !== TIMEOUT || busy !== 1'b0 || seen !== 1'b0) begin
                n_errors++; $display("FAIL timeout_abort: pid cycles=%0d busy=%b cdone=%b required %0d 0 0", n, busy, seen, TIMEOUT);
            end
            n_checks++;
            if (timeout_cnt !== 8'd1 || timeout_flag !== 1'b1) begin
                n_errors++; $display("FAIL timeout_count: cnt=%0d flag=%b required 1 1", timeout_cnt, timeout_flag);
            end
            pulse_tick();
            n_checks++;
            if (imu_req !== 1'b1) begin
                n_errors++; $display("FAIL timeout_next_tick: imu_req=%b required 1", imu_req);
            end
        end else begin
            n_checks++;
            if (pid_req !== 1'b1 || timeout_cnt !== 8'd0 || timeout_flag !== 1'b0) begin
                n_errors++; $display("FAIL no_wdog_waits: pid_req=%b cnt=%0d flag=%b required 1 0 0", pid_req, timeout_cnt, timeout_flag);
            end
        end
        finish_iter();
    endtask

    task automatic test_reset_mid();
        pulse_tick();
        imu_done = 1'b1; cycle(); imu_done = 1'b0;
        pid_done = 1'b1; cycle(); pid_done = 1'b0;
        #10 reset_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if ({imu_req, pid_req, pwm_req, busy, stage} !== 6'd0) begin
            n_errors++; $display("FAIL async_reset: reqs=%b busy=%b stage=%0d required 0", {imu_req, pid_req, pwm_req}, busy, stage);
        end
        cycle(); cycle();
        reset_n = 1'b1;
        cycle();
        pulse_tick();
        n_checks++;
        if (imu_req !== 1'b1 || stage !== 2'd1) begin
            n_errors++; $display("FAIL reset_restart: imu_req=%b stage=%0d required 1 1", imu_req, stage);
        end
        finish_iter();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            tick_en  = ($urandom_range(0, 7) == 0);
            run_en   = ($urandom_range(0, 5) != 0);
            stat_clr = ($urandom_range(0, 63) == 0);
            imu_done = ($urandom_range(0, 2) == 0);
            pid_done = ($urandom_range(0, 2) == 0);
            pwm_done = ($urandom_range(0, 2) == 0);
            cycle();
            n_checks++;
            if (stage !== 2'(m_phase) || imu_req !== (m_phase == 1) || pid_req !== (m_phase == 2) ||
                pwm_req !== (m_phase == 3) || busy !== (m_phase != 0) || cycle_done !== m_cdone) begin
                n_errors++; $display("FAIL rand_ctrl[%0d]: stage=%0d reqs=%b busy=%b cdone=%b required stage=%0d cdone=%b",
                                     i, stage, {imu_req, pid_req, pwm_req}, busy, cycle_done, m_phase, m_cdone);
            end
            n_checks++;
            if (overrun_cnt !== CW'(m_ovr) || overrun_flag !== m_oflag ||
                timeout_cnt !== CW'(m_tmo) || timeout_flag !== m_tflag) begin
                n_errors++; $display("FAIL rand_stats[%0d]: ovr=%0d/%b tmo=%0d/%b required %0d/%b %0d/%b",
                                     i, overrun_cnt, overrun_flag, timeout_cnt, timeout_flag, m_ovr, m_oflag, m_tmo, m_tflag);
            end
        end
        tick_en = 1'b0; stat_clr = 1'b0; run_en = 1'b1;
        imu_done = 1'b0; pid_done = 1'b0; pwm_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_run_en();
        test_tick_pwm_done_and_clr();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_tick_sched.md
# ctrl_tick_sched

Control-loop scheduler driven by the 2 kHz `pid_clk_en` tick from the system clock divider (6000 cycles of `clk_12mhz` per tick). On each tick it runs three stages in a fixed order: IMU sample, PID compute, motor PWM update. Each stage uses a req/done handshake. The block also detects tick overruns and stalled stages, and sits between the divider and the IMU, PID and PWM engines.

## Interface
- `TIMEOUT_CYC`, default 4000: per-stage watchdog limit in `clk_12mhz` cycles.
- `CNT_W`, default 8: width of the saturating statistics counters.
- `clk_12mhz`, in, 1: system clock, 12 MHz.
- `reset_n`, in, 1: asynchronous active-low reset.
- `tick_en`, in, 1: single-cycle loop tick (divider `pid_clk_en`).
- `run_en`, in, 1: when low, ticks are ignored while the block is IDLE.
- `stat_clr`, in, 1: synchronous clear of the counters and sticky flags.
- `imu_req` / `imu_done`, out / in, 1 / 1: IMU stage handshake.
- `pid_req` / `pid_done`, out / in, 1 / 1: PID stage handshake.
- `pwm_req` / `pwm_done`, out / in, 1 / 1: PWM stage handshake.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `cycle_done`, out, 1: single-cycle pulse when a loop iteration completes.
- `stage`, out, 2: current state encoding.
- `overrun_cnt`, out, CNT_W: ticks dropped because the block was busy (saturating).
- `overrun_flag`, out, 1: sticky; set on the first overrun.
- `timeout_cnt`, out, CNT_W: number of watchdog aborts (saturating).
- `timeout_flag`, out, 1: sticky; set on the first watchdog abort.

## Operation
- States: IDLE=0, IMU=1, PID=2, PWM=3.
- IDLE → IMU on `tick_en & run_en`.
- IMU → PID on `imu_done`; PID → PWM on `pid_done`; PWM → IDLE on `pwm_done`, which also pulses `cycle_done`.
- `*_req` is registered: high exactly while in the matching state, and dropped the cycle after its `done` is seen.
- `done` inputs are sampled only in the matching state. A `done` for any other stage is ignored.
- `tick_en` while not IDLE is an overrun:
  - tick dropped, never queued;
  - `overrun_cnt`++ (saturates at all-ones);
  - `overrun_flag` set.
- This includes `tick_en` coinciding with `pwm_done`: counted as an overrun, and the block returns to IDLE.
- Watchdog (only when compiled in):
  - stage counter resets on each state entry and increments every cycle in IMU/PID/PWM;
  - on reaching TIMEOUT_CYC−1 with no `done`: abort to IDLE, all reqs low, no `cycle_done`, `timeout_cnt`++ (saturating), `timeout_flag` set.
- A `done` in the same cycle as the timeout condition wins; the stage advances normally.
- `stat_clr` clears the counters and flags. If an overrun or timeout event occurs in the same cycle, the clear wins.
- `run_en` falling mid-cycle does not abort: the in-progress iteration completes.
- `reset_n` low at any time forces state IDLE with all outputs 0, asynchronously.

## Timing
- Reset values: all reqs 0, `busy` 0, `cycle_done` 0, `stage` 0, counters 0, flags 0.
- Tick at cycle N (IDLE) → `imu_req`=1 and `busy`=1 at N+1.
- `imu_done` sampled at cycle M → `imu_req`=0 and `pid_req`=1 at M+1. PID → PWM follows the same pattern.
- `pwm_done` at cycle K → `pwm_req`=0, `cycle_done`=1 and `busy`=0 at K+1.
- A new tick is accepted at K+1.
- Minimum iteration: 4 cycles from tick to `cycle_done` when each `done` returns the cycle after its req.
- Counter and flag updates are visible the cycle after the event.

## Configuration
- Macro: `CTRL_TICK_SCHED_WDOG_EN`.
- Defined: stage watchdog, `timeout_cnt` and `timeout_flag` are active as specified.
- Undefined: no watchdog counter is synthesised, stages wait indefinitely for `done`, and `timeout_cnt`/`timeout_flag` are tied to 0.

## Structure
- Package `ctrl_pkg` holds:
  - enum `sched_state_e` (IDLE, IMU, PID, PWM);
  - localparam `TICK_PERIOD_CYC` = 6000;
  - default `TIMEOUT_CYC`.
- Sub-module `sat_counter` (parameterised width; inc / clr inputs; saturating) is instantiated for `overrun_cnt` and `timeout_cnt`.
- The FSM and watchdog live in the top module.

## Test plan
- Tick, with each `done` returned 1 cycle after its req → req sequence IMU, PID, PWM; `cycle_done` 4 cycles after the tick; counters stay 0.
- Second tick while in PID → `overrun_cnt`=1, `overrun_flag`=1, iteration still completes; 300 further overruns → `overrun_cnt` saturates at 255.
- WDOG_EN defined, `pid_done` withheld → abort at 4000 cycles in PID, `timeout_cnt`=1, no `cycle_done`, next tick accepted.
- `run_en`=0 with tick in IDLE → no req issued; `run_en` dropped while in IMU → iteration completes and `cycle_done` pulses.
- `tick_en` in the same cycle as `pwm_done` → overrun counted, IDLE next cycle; `stat_clr` in the same cycle as an overrun → `overrun_cnt`=0.
- `reset_n` asserted in PWM → all reqs and `busy` 0 immediately; first tick after release starts at IMU.
